// File: rtl/mul_div_if.sv
// mul_div_if: request/result bundle between the issue logic and the multiply/divide unit.
interface mul_div_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             div_by_zero;
  modport master (output start, op, operand_a, operand_b,
                  input  busy, done, result_lo, result_hi, div_by_zero);
  modport slave  (input  start, op, operand_a, operand_b,
                  output busy, done, result_lo, result_hi, div_by_zero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned shift-add multiply / restoring divide, one bit per clock.
module mul_div_unit #(parameter int WIDTH = 16) (
  input logic     clk,
  input logic     rst,
  mul_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state, state_n;
  logic [CW-1:0]      cnt;
  logic               op_q, busy_q, done_q, dz_q;
  logic [WIDTH-1:0]   a_q, b_q, lo_q, hi_q;
  logic [2*WIDTH-1:0] acc, acc_n, mul_n, div_n;
  logic [WIDTH:0]     add_sum, rem_s;
  logic [WIDTH-1:0]   rem_d;
  logic               rem_ge, accept, last, dz;
  assign accept = bus.start && state != RUN;
  assign last   = state == RUN && cnt == CW'(1);
  assign dz     = op_q && b_q == '0;
  always_comb begin
    state_n = accept ? RUN : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= state_n == RUN;
      done_q <= state_n == DONE;
    end
  end
  // Multiply keeps the carry of the upper-half add in add_sum[WIDTH] before shifting right.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    mul_n   = {add_sum, acc[WIDTH-1:1]};
    rem_s   = acc[2*WIDTH-1:WIDTH-1];
    rem_ge  = rem_s >= {1'b0, b_q};
    rem_d   = rem_s[WIDTH-1:0] - b_q;
    div_n   = {rem_ge ? rem_d : rem_s[WIDTH-1:0], acc[WIDTH-2:0], rem_ge};
    acc_n   = op_q ? div_n : mul_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      op_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      lo_q <= '0;
      hi_q <= '0;
      dz_q <= 1'b0;
    end else if (accept) begin
      cnt  <= CW'(WIDTH);
      op_q <= bus.op;
      a_q  <= bus.operand_a;
      b_q  <= bus.operand_b;
      acc  <= {{WIDTH{1'b0}}, bus.op ? bus.operand_a : bus.operand_b};
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
      acc <= acc_n;
      if (last) begin
        lo_q <= dz ? '1 : acc_n[WIDTH-1:0];
        hi_q <= dz ? a_q : acc_n[2*WIDTH-1:WIDTH];
        dz_q <= dz;
      end
    end
  end
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result_lo   = lo_q;
  assign bus.result_hi   = hi_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a result scoreboard checked whenever done pulses.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dz;
  } exp_t;
  exp_t sb[$];
  mul_div_if #(.WIDTH(16)) bus ();
  mul_div_unit #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result_lo !== e.lo || bus.result_hi !== e.hi || bus.div_by_zero !== e.dz) begin
          errors++;
          $display("FAIL result: got lo=%h hi=%h dz=%b expected lo=%h hi=%h dz=%b",
                   bus.result_lo, bus.result_hi, bus.div_by_zero, e.lo, e.hi, e.dz);
        end
      end
    end
  end
  task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic push, input logic [15:0] lo, input logic [15:0] hi,
                       input logic dz);
    bus.op = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start = 1'b1;
    if (push) sb.push_back('{lo: lo, hi: hi, dz: dz});
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(input logic chk_lat);
    int k = 0;
    int nb = 0;
    bit seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      k = i;
      if (bus.done === 1'b1) seen = 1;
      else if (bus.busy === 1'b1) nb++;
    end
    if (!seen) chk("done_timeout", 32'(k), 32'(0));
    else if (chk_lat) begin
      chk("latency", 32'(k), 32'd17);
      chk("busy_cycles", 32'(nb), 32'd16);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_lo", 32'(bus.result_lo), 32'd0);
    chk("reset_hi", 32'(bus.result_hi), 32'd0);
    chk("reset_dz", 32'(bus.div_by_zero), 32'd0);
    issue(1'b0, 16'd300, 16'd200, 1'b1, 16'hEA60, 16'h0000, 1'b0);
    wait_done(1'b1);
    @(negedge clk);
    chk("done_pulse_width", 32'(bus.done), 32'd0);
    chk("result_hold", 32'(bus.result_lo), 32'hEA60);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'hFFFE, 1'b0);
    wait_done(1'b1);
    @(negedge clk);
    issue(1'b0, 16'h0000, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0);
    wait_done(1'b1);
    @(negedge clk);
    issue(1'b1, 16'd1000, 16'd7, 1'b1, 16'd142, 16'd6, 1'b0);
    wait_done(1'b1);
    @(negedge clk);
    issue(1'b1, 16'd5, 16'd9, 1'b1, 16'd0, 16'd5, 1'b0);
    wait_done(1'b1);
    @(negedge clk);
    issue(1'b1, 16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1);
    wait_done(1'b1);
    @(negedge clk);
    issue(1'b0, 16'd3, 16'd4, 1'b1, 16'd12, 16'd0, 1'b0);
    wait_done(1'b1);
    @(negedge clk);
    issue(1'b0, 16'd300, 16'd200, 1'b1, 16'hEA60, 16'h0000, 1'b0);
    repeat (4) @(negedge clk);
    issue(1'b0, 16'd1, 16'd1, 1'b0, 16'd0, 16'd0, 1'b0);
    wait_done(1'b0);
    issue(1'b1, 16'd100, 16'd10, 1'b1, 16'd10, 16'd0, 1'b0);
    wait_done(1'b1);
    @(negedge clk);
    issue(1'b1, 16'd1000, 16'd7, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_lo", 32'(bus.result_lo), 32'd0);
    chk("abort_hi", 32'(bus.result_hi), 32'd0);
    chk("abort_dz", 32'(bus.div_by_zero), 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    issue(1'b1, 16'd1000, 16'd7, 1'b1, 16'd142, 16'd6, 1'b0);
    wait_done(1'b1);
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
